// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch controller slice.
// Holds the FSM state encoding and the saturation limit helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    SW_IDLE  = 2'd0,
    SW_RUN   = 2'd1,
    SW_PAUSE = 2'd2,
    SW_OVF   = 2'd3
  } sw_state_t;

  // Largest count representable in w bits; callers cast down to their own width.
  function automatic logic [31:0] cnt_max(input int unsigned w);
    logic [32:0] one_shifted;
    one_shifted = 33'd1 << w;
    return 32'(one_shifted - 33'd1);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_lap_fifo.sv
// Small synchronous show-ahead FIFO holding captured lap times.
// The head is presented combinationally and reads as zero while empty.
module lap_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == CNT_W'(0));
  assign full    = (count == CNT_W'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/pause/resume/clear of a saturating ms count
// advanced by an external 1-ms tick, with lap capture into a small FIFO.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int LAP_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ms_tick,
  input  logic                           start_stop,
  input  logic                           lap,
  input  logic                           clear,
  input  logic                           lap_pop,
  output logic [CNT_W-1:0]               cnt_ms,
  output logic                           running,
  output logic                           paused,
  output logic                           ovf,
  output logic [CNT_W-1:0]               lap_ms,
  output logic                           lap_valid,
  output logic [$clog2(LAP_DEPTH+1)-1:0] lap_cnt,
  output logic                           lap_drop
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  sw_state_t        state;
  sw_state_t        state_d;
  logic [CNT_W-1:0] cnt_d;
  logic             at_max;
  logic             lap_push;
  logic             fifo_full;
  logic             fifo_empty;

  assign at_max = (cnt_ms == CNT_MAX);

  // Next-state and next-count; clear overrides everything, start_stop beats lap.
  always_comb begin
    state_d = state;
    cnt_d   = cnt_ms;
    if (clear) begin
      state_d = SW_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state)
        SW_IDLE: begin
          cnt_d = '0;
          if (start_stop) begin
            state_d = SW_RUN;
          end
        end
        SW_RUN: begin
          if (ms_tick && at_max) begin
            state_d = SW_OVF;
          end else begin
            if (ms_tick) begin
              cnt_d = cnt_ms + CNT_W'(1);
            end
            if (start_stop) begin
              state_d = SW_PAUSE;
            end
          end
        end
        SW_PAUSE: begin
          if (start_stop) begin
            state_d = SW_RUN;
          end
        end
        SW_OVF: begin
          cnt_d = CNT_MAX;
        end
        default: begin
          state_d = SW_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SW_IDLE;
      cnt_ms  <= '0;
      running <= 1'b0;
      paused  <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_d;
      cnt_ms  <= cnt_d;
      running <= (state_d == SW_RUN);
      paused  <= (state_d == SW_PAUSE);
      ovf     <= (state_d == SW_OVF);
    end
  end

  // Laps are only captured while running and when no higher-priority command is present.
  assign lap_push = (state == SW_RUN) && lap && !start_stop && !clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_drop <= 1'b0;
    end else if (clear) begin
      lap_drop <= 1'b0;
    end else if (lap_push && fifo_full && !(lap_pop && !fifo_empty)) begin
      lap_drop <= 1'b1;
    end
  end

  lap_fifo #(
    .WIDTH (CNT_W),
    .DEPTH (LAP_DEPTH)
  ) u_lap_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (lap_push),
    .push_data (cnt_ms),
    .pop       (lap_pop),
    .flush     (clear),
    .head      (lap_ms),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (lap_cnt)
  );

  assign lap_valid = !fifo_empty;

endmodule
